// File: rtl/mam_nasti_pkg.sv
// Shared types and constants for the MAM-to-NASTI bridge: FSM states,
// NASTI response/burst encodings and the beat-size helper.
package mam_nasti_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Bursts must not cross this address granule when splitting is enabled.
  localparam int unsigned BOUNDARY_BYTES = 4096;

  // log2 of the beat size in bytes, i.e. the NASTI size encoding.
  function automatic int unsigned size_log2(input int unsigned bytes);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < bytes) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mam_nasti_chunker.sv
// Chunk length for the next NASTI burst: min(rem, MAX_BEATS, beats to the
// next 4 KiB page). The page term exists only with MAM_NASTI_BOUNDARY_SPLIT_EN.
module mam_nasti_chunker
  import mam_nasti_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic [11:0] addr,
  input  logic [13:0] rem,
  output logic [8:0]  len
);

  localparam int unsigned SIZE    = size_log2(DATA_WIDTH / 8);
  localparam logic [13:0] MAX_CAP = 14'(MAX_BEATS);

`ifdef MAM_NASTI_BOUNDARY_SPLIT_EN
  logic [12:0] page_left;
  logic [13:0] page_beats;

  // addr is beat-aligned, so page_left is always a whole number of beats (>= 1).
  assign page_left  = 13'(BOUNDARY_BYTES) - {1'b0, addr};
  assign page_beats = {1'b0, page_left >> SIZE};
`else
  logic unused_addr;
  assign unused_addr = ^addr;
`endif

  logic [13:0] cap;

  always_comb begin
    cap = (rem > MAX_CAP) ? MAX_CAP : rem;
`ifdef MAM_NASTI_BOUNDARY_SPLIT_EN
    if (page_beats < cap) cap = page_beats;
`endif
    len = 9'(cap);
  end

endmodule

// File: rtl/mam_nasti_bridge.sv
// Splits MAM memory requests into NASTI INCR bursts, one outstanding at a time.
// Optional 4 KiB burst splitting: define MAM_NASTI_BOUNDARY_SPLIT_EN.
module mam_nasti_bridge
  import mam_nasti_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  // MAM request / data ports
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    read_valid,
  input  logic                    read_ready,
  output logic [DATA_WIDTH-1:0]   read_data,
  // NASTI write address / data / response
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic [7:0]              aw_len,
  output logic [2:0]              aw_size,
  output logic [1:0]              aw_burst,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_last,
  output logic                    w_valid,
  input  logic                    w_ready,
  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready,
  // NASTI read address / data
  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic [7:0]              ar_len,
  output logic [2:0]              ar_size,
  output logic [1:0]              ar_burst,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_last,
  input  logic                    r_valid,
  output logic                    r_ready,
  output logic                    err
);

  localparam int unsigned SIZE = size_log2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [13:0]             rem_q, rem_d;
  logic [8:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [8:0]              chunk_len;
  logic [13:0]             rem_left;
  logic [ADDR_WIDTH-1:0]   addr_next;

  // addr_q/rem_q only change at chunk ends, so chunk_len is stable for a whole burst.
  mam_nasti_chunker #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_chunker (
    .addr (addr_q[11:0]),
    .rem  (rem_q),
    .len  (chunk_len)
  );

  assign rem_left  = rem_q - {5'd0, chunk_len};
  assign addr_next = addr_q + (ADDR_WIDTH'(chunk_len) << SIZE);

  // Data paths are pure passthrough; the handshakes are gated by state.
  assign read_data = r_data;
  assign w_data    = write_data;
  assign w_strb    = write_strb;
  assign err       = err_q;

  // NOTE: every state register is reset asynchronously, so a mid-burst reset
  // abandons the transfer and returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    write_ready = 1'b0;
    read_valid  = 1'b0;
    r_ready     = 1'b0;
    aw_addr     = '0;
    aw_len      = '0;
    aw_size     = '0;
    aw_burst    = '0;
    aw_valid    = 1'b0;
    w_last      = 1'b0;
    w_valid     = 1'b0;
    b_ready     = 1'b0;
    ar_addr     = '0;
    ar_len      = '0;
    ar_size     = '0;
    ar_burst    = '0;
    ar_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr & ALIGN_MASK;
          rem_d   = (req_burst && req_beats != 14'd0) ? req_beats : 14'd1;
          err_d   = 1'b0;
          state_d = req_rw ? S_WR_ADDR : S_RD_ADDR;
        end
      end

      S_RD_ADDR: begin
        ar_valid = 1'b1;
        ar_addr  = addr_q;
        ar_len   = 8'(chunk_len - 9'd1);
        ar_size  = 3'(SIZE);
        ar_burst = BURST_INCR;
        if (ar_ready) state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        read_valid = r_valid;
        r_ready    = read_ready;
        if (r_valid && read_ready) begin
          if (r_resp != RESP_OKAY) err_d = 1'b1;
          if (r_last) begin
            addr_d  = addr_next;
            rem_d   = rem_left;
            state_d = (rem_left == 14'd0) ? S_IDLE : S_RD_ADDR;
          end
        end
      end

      S_WR_ADDR: begin
        aw_valid = 1'b1;
        aw_addr  = addr_q;
        aw_len   = 8'(chunk_len - 9'd1);
        aw_size  = 3'(SIZE);
        aw_burst = BURST_INCR;
        if (aw_ready) begin
          cnt_d   = chunk_len;
          state_d = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        w_valid     = write_valid;
        write_ready = w_ready;
        w_last      = (cnt_q == 9'd1);
        if (write_valid && w_ready) begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_resp != RESP_OKAY) err_d = 1'b1;
          addr_d  = addr_next;
          rem_d   = rem_left;
          state_d = (rem_left == 14'd0) ? S_IDLE : S_WR_ADDR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mam_nasti_bridge.sv
// Directed self-checking bench for mam_nasti_bridge at DATA_WIDTH = 512;
// burst-split expectations follow MAM_NASTI_BOUNDARY_SPLIT_EN.
module tb_mam_nasti_bridge;

  localparam int DW = 512;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_rw, req_burst;
  logic [AW-1:0] req_addr;
  logic [13:0]   req_beats;
  logic          write_valid, write_ready;
  logic [DW-1:0] write_data;
  logic [DW/8-1:0] write_strb;
  logic          read_valid, read_ready;
  logic [DW-1:0] read_data;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0]    aw_len, ar_len;
  logic [2:0]    aw_size, ar_size;
  logic [1:0]    aw_burst, ar_burst;
  logic          aw_valid, aw_ready, ar_valid, ar_ready;
  logic [DW-1:0] w_data, r_data;
  logic [DW/8-1:0] w_strb;
  logic          w_last, w_valid, w_ready;
  logic [1:0]    b_resp, r_resp;
  logic          b_valid, b_ready;
  logic          r_last, r_valid, r_ready;
  logic          err;

  int checks = 0;
  int errors = 0;

  mam_nasti_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BEATS(256)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_data(write_data), .write_strb(write_strb),
    .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid),
    .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic rw, input logic [63:0] a,
                         input logic burst, input logic [13:0] beats);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_burst = burst;
    req_beats = beats;
    #1;
    check("req_ready_idle", req_ready, 1);
    check("addr_valid_before_accept", aw_valid | ar_valid, 0);
    tick();
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
  endtask

  // One read burst: address phase, then len_m1+1 beats; stall adds one cycle
  // of read_ready back-pressure on the first beat.
  task automatic rd_chunk(input logic [63:0] a, input int len_m1,
                          input bit stall, input bit final_chunk);
    logic [DW-1:0] d;
    check("ar_valid", ar_valid, 1);
    check("ar_addr", ar_addr, a);
    check("ar_len", ar_len, 64'(len_m1));
    check("ar_size", ar_size, 6);
    check("ar_burst", ar_burst, 1);
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    check("ar_valid_after_hs", ar_valid, 0);
    for (int i = 0; i <= len_m1; i++) begin
      d        = {16{32'h1000_0000 + 32'(i)}};
      r_valid  = 1'b1;
      r_data   = d;
      r_resp   = 2'b00;
      r_last   = (i == len_m1);
      if (stall && i == 0) begin
        read_ready = 1'b0;
        #1;
        check("r_ready_backpressure", r_ready, 0);
        check("read_valid_stall", read_valid, 1);
        tick();
      end
      read_ready = 1'b1;
      #1;
      if (i == 0 || i == len_m1) begin
        check("read_valid", read_valid, 1);
        check("r_ready", r_ready, 1);
        check("read_data", 64'(read_data == d), 1);
      end
      tick();
    end
    r_valid    = 1'b0;
    r_last     = 1'b0;
    read_ready = 1'b0;
    check("req_ready_after_r_last", req_ready, 64'(final_chunk));
  endtask

  // One write burst: address phase, len_m1+1 beats with w_last checked on
  // every beat, then a B response carrying resp.
  task automatic wr_chunk(input logic [63:0] a, input int len_m1,
                          input logic [1:0] resp, input bit final_chunk);
    logic [DW-1:0] d;
    check("aw_valid", aw_valid, 1);
    check("aw_addr", aw_addr, a);
    check("aw_len", aw_len, 64'(len_m1));
    check("aw_size", aw_size, 6);
    check("aw_burst", aw_burst, 1);
    check("write_ready_in_wr_addr", write_ready, 0);
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    for (int i = 0; i <= len_m1; i++) begin
      d           = {16{32'hA000_0000 + 32'(i)}};
      write_valid = 1'b1;
      write_data  = d;
      write_strb  = {8{8'(i + 1)}};
      w_ready     = 1'b1;
      #1;
      check("w_last", w_last, 64'(i == len_m1));
      if (i == 0 || i == len_m1) begin
        check("w_valid", w_valid, 1);
        check("write_ready", write_ready, 1);
        check("w_data", 64'(w_data == d), 1);
        check("w_strb", w_strb, {8{8'(i + 1)}});
      end
      tick();
    end
    write_valid = 1'b0;
    w_ready     = 1'b0;
    check("w_valid_after_burst", w_valid, 0);
    check("b_ready", b_ready, 1);
    b_valid = 1'b1;
    b_resp  = resp;
    tick();
    b_valid = 1'b0;
    b_resp  = 2'b00;
    check("req_ready_after_b", req_ready, 64'(final_chunk));
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 0; req_rw = 0; req_addr = '0; req_burst = 0; req_beats = '0;
    write_valid = 0; write_data = '0; write_strb = '0; read_ready = 0;
    aw_ready = 0; w_ready = 0; b_resp = 0; b_valid = 0; ar_ready = 0;
    r_data = '0; r_resp = 0; r_last = 0; r_valid = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_err", err, 0);
    check("rst_valids", {aw_valid, ar_valid, w_valid, read_valid}, 0);
    check("rst_readies", {write_ready, r_ready, b_ready}, 0);
    check("rst_w_last", w_last, 0);
    check("rst_aw_addr_len_size", {aw_addr[15:0], aw_len, aw_size}, 0);
    check("rst_ar_addr_len_size", {ar_addr[15:0], ar_len, ar_size}, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single-beat read, unaligned address is truncated to the beat.
    request(1'b0, 64'h1008, 1'b0, 14'd0);
    check("err_after_accept", err, 0);
    rd_chunk(64'h1000, 0, 1'b1, 1'b1);

    // 100-beat write at 0x0F80.
`ifdef MAM_NASTI_BOUNDARY_SPLIT_EN
    request(1'b1, 64'h0F80, 1'b1, 14'd100);
    wr_chunk(64'h0F80, 1, 2'b00, 1'b0);
    wr_chunk(64'h1000, 63, 2'b00, 1'b0);
    wr_chunk(64'h2000, 33, 2'b00, 1'b1);
`else
    request(1'b1, 64'h0F80, 1'b1, 14'd100);
    wr_chunk(64'h0F80, 99, 2'b00, 1'b1);
`endif
    check("err_clean_write", err, 0);

    // 300-beat read at 0.
    request(1'b0, 64'h0, 1'b1, 14'd300);
`ifdef MAM_NASTI_BOUNDARY_SPLIT_EN
    rd_chunk(64'h0000, 63, 1'b0, 1'b0);
    rd_chunk(64'h1000, 63, 1'b0, 1'b0);
    rd_chunk(64'h2000, 63, 1'b0, 1'b0);
    rd_chunk(64'h3000, 63, 1'b0, 1'b0);
    rd_chunk(64'h4000, 43, 1'b0, 1'b1);
`else
    rd_chunk(64'h0000, 255, 1'b0, 1'b0);
    rd_chunk(64'h4000, 43, 1'b0, 1'b1);
`endif

    // SLVERR on the first of two write bursts: err is sticky, transfer completes.
`ifdef MAM_NASTI_BOUNDARY_SPLIT_EN
    request(1'b1, 64'h0F80, 1'b1, 14'd4);
    wr_chunk(64'h0F80, 1, 2'b10, 1'b0);
    check("err_set", err, 1);
    wr_chunk(64'h1000, 1, 2'b00, 1'b1);
`else
    request(1'b1, 64'h0, 1'b1, 14'd258);
    wr_chunk(64'h0000, 255, 2'b10, 1'b0);
    check("err_set", err, 1);
    wr_chunk(64'h4000, 1, 2'b00, 1'b1);
`endif
    check("err_sticky", err, 1);

    // Next request clears err; burst with zero beats means one beat.
    request(1'b0, 64'h47, 1'b1, 14'd0);
    check("err_cleared", err, 0);
    rd_chunk(64'h40, 0, 1'b0, 1'b1);

    // Reset in the middle of a write data phase.
    request(1'b1, 64'h0, 1'b1, 14'd10);
    check("aw_valid_before_reset", aw_valid, 1);
    aw_ready = 1'b1;
    tick();
    aw_ready    = 1'b0;
    write_valid = 1'b1;
    w_ready     = 1'b1;
    repeat (3) tick();
    check("w_valid_mid_burst", w_valid, 1);
    rstn = 1'b0;
    #1;
    check("rst_mid_w_valid", w_valid, 0);
    check("rst_mid_write_ready", write_ready, 0);
    check("rst_mid_addr_valids", {aw_valid, ar_valid}, 0);
    check("rst_mid_b_ready", b_ready, 0);
    write_valid = 1'b0;
    w_ready     = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("req_ready_after_reset", req_ready, 1);
    check("err_after_reset", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
